spi_arbiter: RTL and testbench

Shares a single SPI byte engine between two requesters, for example the CPU SPI port and the SD-card boot loader. It grants ownership with round-robin arbitration and drives one active-low chip select per requester, with programmable setup and hold gaps. While a requester is granted it may pass any number of bytes through the engine. The block sits between the requesters and the byte engine; the engine's cpu_clk is tied to clki, so the whole block runs in one clock domain.

---
 rtl/spi_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin owner of one SPI byte engine, two requesters.
// Optional watchdog on stuck bytes: define SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic       clki,
  input  logic       rst,
  input  logic [1:0] req_lock,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  input  logic [1:0] req_send,
  output logic [1:0] req_grant,
  output logic [1:0] req_rdy,
  output logic [1:0] req_done,
  output logic [7:0] rx_data,
  output logic       err,
  output logic [1:0] cs_n,
  output logic [7:0] eng_data,
  output logic       eng_send,
  input  logic [7:0] eng_rx,
  input  logic       eng_ready
);

  typedef enum logic [2:0] {
    IDLE, SETUP, READY, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       hold_hi;
  logic       own;
  logic       last;

  logic       own_lock;
  logic       own_send;
  logic [7:0] own_data;
  logic       any_lock;
  logic       win;
  logic       in_wait;
  logic       done_ok;
  logic       wd_fire;
  logic       byte_end;
  logic [7:0] rx_next;

  assign own_lock = req_lock[own];
  assign own_send = req_send[own];
  assign own_data = own ? req1_data : req0_data;
  assign any_lock = |req_lock;
  assign in_wait  = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign done_ok  = (state == WAIT_DONE) && eng_ready;
  assign byte_end = done_ok || wd_fire;
  assign rx_next  = done_ok ? eng_rx : 8'hFF;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    win = 1'b0;
    unique case (req_lock)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd;

  assign wd_fire = in_wait && !done_ok &&
                   (wd == WW'(TIMEOUT - 1));

  // Counts from ISSUE onward; cleared while waiting in READY.
  always_ff @(posedge clki) begin
    if (rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      err <= wd_fire;
      if (state == READY)
        wd <= '0;
      else if (state == ISSUE || in_wait)
        wd <= wd + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clki) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_hi   <= 1'b0;
      own       <= 1'b0;
      last      <= 1'b1;
      req_grant <= 2'b00;
      req_rdy   <= 2'b00;
      req_done  <= 2'b00;
      rx_data   <= 8'h00;
      cs_n      <= 2'b11;
      eng_data  <= 8'h00;
      eng_send  <= 1'b0;
    end else begin
      req_done <= 2'b00;
      eng_send <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_lock) begin
            own       <= win;
            req_grant <= win ? 2'b10 : 2'b01;
            cs_n      <= win ? 2'b01 : 2'b10;
            cnt       <= 4'(CS_SETUP);
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            req_rdy <= req_grant;
            state   <= READY;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        READY: begin
          if (!own_lock) begin
            req_rdy <= 2'b00;
            cnt     <= 4'(CS_HOLD);
            hold_hi <= 1'b0;
            state   <= HOLD;
          end else if (own_send) begin
            eng_data <= own_data;
            req_rdy  <= 2'b00;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          eng_send <= 1'b1;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (byte_end) begin
            rx_data  <= rx_next;
            req_done <= req_grant;
            if (own_lock) begin
              req_rdy <= req_grant;
              state   <= READY;
            end else begin
              cnt     <= 4'(CS_HOLD);
              hold_hi <= 1'b0;
              state   <= HOLD;
            end
          end else if (state == WAIT_BUSY && !eng_ready) begin
            state <= WAIT_DONE;
          end
        end
        HOLD: begin
          // First count with cs_n low, second with all cs_n high.
          if (cnt <= 4'd1) begin
            if (!hold_hi) begin
              hold_hi <= 1'b1;
              cs_n    <= 2'b11;
              cnt     <= 4'(CS_HOLD);
            end else begin
              hold_hi   <= 1'b0;
              last      <= own;
              req_grant <= 2'b00;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: vector table, directed corner sequences and a
// randomized run scored against a byte-queue model of the arbiter.
module tb_spi_arbiter;

  localparam int CS_S = 2;
  localparam int CS_H = 3;
  localparam int TO   = 40;

  logic       clki = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_lock = 2'b00;
  logic [7:0] req0_data = 8'h00;
  logic [7:0] req1_data = 8'h00;
  logic [1:0] req_send = 2'b00;
  logic [1:0] req_grant;
  logic [1:0] req_rdy;
  logic [1:0] req_done;
  logic [7:0] rx_data;
  logic       err;
  logic [1:0] cs_n;
  logic [7:0] eng_data;
  logic       eng_send;
  logic [7:0] eng_rx = 8'h00;
  logic       eng_ready = 1'b1;

  spi_arbiter #(
    .CS_SETUP(CS_S),
    .CS_HOLD (CS_H),
    .TIMEOUT (TO)
  ) dut (
    .clki     (clki),
    .rst      (rst),
    .req_lock (req_lock),
    .req0_data(req0_data),
    .req1_data(req1_data),
    .req_send (req_send),
    .req_grant(req_grant),
    .req_rdy  (req_rdy),
    .req_done (req_done),
    .rx_data  (rx_data),
    .err      (err),
    .cs_n     (cs_n),
    .eng_data (eng_data),
    .eng_send (eng_send),
    .eng_rx   (eng_rx),
    .eng_ready(eng_ready)
  );

  always #5 clki = ~clki;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Engine: drops ready 1-2 cycles after a send, returns byte^rx_xor later.
  logic       eng_dead = 1'b0;
  logic [7:0] rx_xor = 8'h00;
  int         e_ph = 0;
  int         e_cnt = 0;
  logic [7:0] e_byte = 8'h00;

  always @(posedge clki) begin
    #2;
    if (rst) begin
      eng_ready = 1'b1;
      e_ph = 0;
    end else if (e_ph == 0) begin
      if (eng_send && !eng_dead) begin
        e_byte = eng_data;
        e_cnt = $urandom_range(1, 2);
        e_ph = 1;
      end
    end else begin
      e_cnt--;
      if (e_cnt == 0) begin
        if (e_ph == 1) begin
          eng_ready = 1'b0;
          eng_rx = 8'($urandom);
          e_cnt = $urandom_range(1, 5);
          e_ph = 2;
        end else begin
          eng_rx = e_byte ^ rx_xor;
          eng_ready = 1'b1;
          e_ph = 0;
        end
      end
    end
  end

  // Ownership invariants and cs_n high gap between selections.
  int n_eng = 0;
  int inv_bad = 0;
  int gap_bad = 0;
  int hi_run = 0;
  bit seen_low = 1'b0;

  always @(negedge clki) begin
    if (eng_send) n_eng++;
    if (!rst) begin
      if (req_grant == 2'b11 || cs_n == 2'b00 ||
          (~cs_n & ~req_grant) != 2'b00 ||
          (req_rdy & ~req_grant) != 2'b00 ||
          (req_done & ~req_grant) != 2'b00 ||
          (eng_send && req_grant == 2'b00) ||
          (err && !eng_dead))
        inv_bad++;
      if (cs_n == 2'b11) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0 && hi_run < CS_H) gap_bad++;
        hi_run = 0;
        seen_low = 1'b1;
      end
    end else begin
      hi_run = 0;
      seen_low = 1'b0;
    end
  end

  task automatic chk_reset(input string nm);
    chk(nm, {req_grant, req_rdy, req_done, err, eng_send, cs_n,
             eng_data, rx_data},
        {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 8'h00, 8'h00});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_lock = 2'b00;
    req_send = 2'b00;
    repeat (3) @(negedge clki);
    chk_reset("reset_vals");
    rst = 1'b0;
  endtask

  task automatic wait_rdy(input logic [1:0] g);
    int k = 0;
    while (req_rdy != g && k < 40) begin
      @(negedge clki);
      k++;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (req_done == 2'b00 && k < 80) begin
      @(negedge clki);
      k++;
    end
  endtask

  task automatic wait_release();
    int k = 0;
    while (req_grant != 2'b00 && k < 60) begin
      @(negedge clki);
      k++;
    end
    chk("release", {req_grant, cs_n}, {2'b00, 2'b11});
  endtask

  // Randomized-run scoreboard: accepted bytes per requester, in order.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_sb = 0;

  task automatic sb_check();
    logic [7:0] e;
    if (req_done[0]) begin
      if (q0.size() == 0) chk("sb_extra0", q0.size(), 1);
      else begin
        e = q0.pop_front();
        chk("sb_rx0", rx_data, e ^ rx_xor);
        n_sb++;
      end
    end
    if (req_done[1]) begin
      if (q1.size() == 0) chk("sb_extra1", q1.size(), 1);
      else begin
        e = q1.pop_front();
        chk("sb_rx1", rx_data, e ^ rx_xor);
        n_sb++;
      end
    end
  endtask

  typedef struct {
    logic [1:0] lock;
    logic [7:0] d;
    logic [1:0] eg;
    logic [1:0] ecs;
    logic [7:0] erx;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input vec_t v);
    int base;
    req_lock = v.lock;
    req0_data = v.eg[0] ? v.d : ~v.d;
    req1_data = v.eg[1] ? v.d : ~v.d;
    @(negedge clki);
    chk("grant", req_grant, v.eg);
    chk("cs_n_low", cs_n, v.ecs);
    repeat (CS_S) @(negedge clki);
    chk("rdy_early", req_rdy, 2'b00);
    @(negedge clki);
    chk("rdy", req_rdy, v.eg);
    base = n_eng;
    req_send = v.lock;
    @(negedge clki);
    req_send = 2'b00;
    chk("send_early", eng_send, 1'b0);
    @(negedge clki);
    chk("eng_send", {eng_send, eng_data}, {1'b1, v.d});
    wait_done();
    chk("done", req_done, v.eg);
    chk("rx", rx_data, v.erx);
    chk("rdy_on_done", req_rdy, v.eg);
    req_lock = 2'b00;
    wait_release();
    chk("one_send", n_eng - base, 1);
  endtask

  initial begin
    tbl[0] = '{2'b11, 8'hA5, 2'b01, 2'b10, 8'hA5};
    tbl[1] = '{2'b11, 8'h3C, 2'b10, 2'b01, 8'h3C};
    tbl[2] = '{2'b01, 8'hC3, 2'b01, 2'b10, 8'hC3};
    tbl[3] = '{2'b10, 8'h00, 2'b10, 2'b01, 8'h00};
    tbl[4] = '{2'b10, 8'hFF, 2'b10, 2'b01, 8'hFF};
    tbl[5] = '{2'b11, 8'h5A, 2'b01, 2'b10, 8'h5A};
    tbl[6] = '{2'b11, 8'h81, 2'b10, 2'b01, 8'h81};
    tbl[7] = '{2'b01, 8'h7E, 2'b01, 2'b10, 8'h7E};

    do_reset();
    foreach (tbl[i]) run_vec(tbl[i]);

    // Tie right after reset, then hand over to requester 1.
    begin
      int k = 0;
      do_reset();
      req_lock = 2'b11;
      @(negedge clki);
      chk("tie_grant", {req_grant, cs_n}, {2'b01, 2'b10});
      req_lock = 2'b10;
      while (req_grant != 2'b10 && k < 60) begin
        @(negedge clki);
        k++;
      end
      chk("handover", {req_grant, cs_n}, {2'b10, 2'b01});
    end

    // Burst of three bytes, each sent on the previous req_done cycle.
    begin
      int bad = 0;
      int base;
      wait_rdy(2'b10);
      for (int b = 1; b <= 3; b++) begin
        req1_data = 8'(b);
        req_send = 2'b10;
        @(negedge clki);
        req_send = 2'b00;
        for (int k = 0; k < 80 && req_done == 2'b00; k++) begin
          if (cs_n != 2'b01 || req_grant != 2'b10) bad++;
          @(negedge clki);
        end
        chk("burst_done", req_done, 2'b10);
        chk("burst_rx", rx_data, 8'(b));
        chk("burst_rdy", req_rdy, 2'b10);
      end
      chk("burst_cs", bad, 0);

      // Lock dropped mid-byte, plus a stray send from the non-owner.
      base = n_eng;
      req1_data = 8'h04;
      req_send = 2'b10;
      @(negedge clki);
      req_send = 2'b00;
      for (int k = 0; k < 20 && eng_ready; k++) @(negedge clki);
      req_lock = 2'b00;
      req0_data = 8'hEE;
      req_send = 2'b01;
      @(negedge clki);
      req_send = 2'b00;
      if (req_done == 2'b00) wait_done();
      chk("drop_done", req_done, 2'b10);
      chk("drop_rx", rx_data, 8'h04);
      wait_release();
      chk("nonowner_send", n_eng - base, 1);
    end

    // Reset while the engine is busy with a byte.
    begin
      req_lock = 2'b01;
      req0_data = 8'hAA;
      wait_rdy(2'b01);
      req_send = 2'b01;
      @(negedge clki);
      req_send = 2'b00;
      @(negedge clki);
      chk("rst_pre_send", eng_send, 1'b1);
      rst = 1'b1;
      @(negedge clki);
      chk_reset("rst_busy");
      rst = 1'b0;
      req_lock = 2'b10;
      @(negedge clki);
      chk("rst_regrant", {req_grant, cs_n}, {2'b10, 2'b01});
      wait_rdy(2'b10);
      chk("rst_rdy", req_rdy, 2'b10);
      req_lock = 2'b00;
      wait_release();
    end

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int k = 1;
      req_lock = 2'b01;
      req0_data = 8'h5A;
      wait_rdy(2'b01);
      eng_dead = 1'b1;
      req_send = 2'b01;
      @(negedge clki);
      req_send = 2'b00;
      while (!err && k < TO + 20) begin
        @(negedge clki);
        k++;
      end
      chk("wd_latency", k, TO + 1);
      chk("wd_done", {req_done, rx_data}, {2'b01, 8'hFF});
      req_lock = 2'b00;
      @(negedge clki);
      chk("wd_err_pulse", err, 1'b0);
      eng_dead = 1'b0;
      wait_release();
    end
`endif

    // Randomized traffic against the byte-queue model.
    begin
      int k = 0;
      rx_xor = 8'h5A;
      for (int c = 0; c < 800; c++) begin
        @(negedge clki);
        sb_check();
        for (int i = 0; i < 2; i++) begin
          if ($urandom_range(0, 19) == 0) req_lock[i] = ~req_lock[i];
          req_send[i] = ($urandom_range(0, 2) == 0);
        end
        req0_data = 8'($urandom);
        req1_data = 8'($urandom);
        if (req_rdy[0] && req_lock[0] && req_send[0])
          q0.push_back(req0_data);
        if (req_rdy[1] && req_lock[1] && req_send[1])
          q1.push_back(req1_data);
      end
      req_lock = 2'b00;
      req_send = 2'b00;
      while ((req_grant != 2'b00 || q0.size() + q1.size() != 0) &&
             k < 300) begin
        @(negedge clki);
        sb_check();
        k++;
      end
      chk("drained", q0.size() + q1.size(), 0);
      chk("rand_activity", n_sb > 10, 1'b1);
    end

    chk("invariants", inv_bad, 0);
    chk("cs_gap", gap_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
